// File: rtl/usb_slfifo_pkg.sv
// Shared definitions for the FX2 slave-FIFO write sequencer.
package usb_slfifo_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_BURST  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // FIFOADR[1:0] endpoint selects
  localparam logic [1:0] FIFOADR_EP2 = 2'b00;
  localparam logic [1:0] FIFOADR_EP4 = 2'b01;
  localparam logic [1:0] FIFOADR_EP6 = 2'b10;
  localparam logic [1:0] FIFOADR_EP8 = 2'b11;

  // Cycles spent with all strobes high after a commit, so FX2 flags settle
  localparam int unsigned GAP_CYCLES = 2;
  // Consecutive not-full samples required before a packet is started
  localparam int unsigned ARM_QUAL   = 2;

  // 16-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_slfifo_wr_ctrl.sv
// Write sequencer for the CY7C68013A slave FIFO (EP6 IN, 16-bit sync mode).
// Takes a valid/ready word stream, writes it into the FX2 FIFO one packet at
// a time, and commits partial packets with PKTEND on idle timeout or disable.
module usb_slfifo_wr_ctrl
  import usb_slfifo_pkg::*;
#(
  parameter int unsigned PKT_WORDS    = 256,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter logic [1:0]  FIFO_ADDR    = FIFOADR_EP6
) (
  input  logic        i_usb_ifclk,
  input  logic        i_usb_reset,
  input  logic        i_enable,
  input  logic [15:0] i_s_data,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  input  logic        i_flag_full_n,
  output logic [15:0] o_usb_fd,
  output logic        o_usb_slwr_n,
  output logic        o_usb_slrd_n,
  output logic        o_usb_sloe_n,
  output logic        o_usb_pktend_n,
  output logic [1:0]  o_usb_fifoadr,
  output logic        o_busy,
  output logic [15:0] o_pkt_cnt
);

  localparam int unsigned       WCNT_W       = $clog2(PKT_WORDS + 1);
  localparam logic [WCNT_W-1:0] LP_PKT_WORDS = WCNT_W'(PKT_WORDS);
  localparam logic [WCNT_W-1:0] LP_WCNT_ZERO = {WCNT_W{1'b0}};
  localparam logic [WCNT_W-1:0] LP_WCNT_ONE  = WCNT_W'(1);
  localparam logic [15:0]       LP_TIMEOUT   = 16'(IDLE_TIMEOUT);
  localparam logic [1:0]        LP_ARM_QUAL  = 2'(ARM_QUAL);
  localparam logic [1:0]        LP_GAP_LAST  = 2'(GAP_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic [WCNT_W-1:0] w_wcnt_inc;
  logic [15:0]       r_idle;
  logic [15:0]       w_idle_nxt;
  logic [15:0]       w_idle_inc;
  logic [1:0]        r_qual;
  logic [1:0]        w_qual_nxt;
  logic [1:0]        w_qual_inc;
  logic [1:0]        r_gap;
  logic [1:0]        w_gap_nxt;
  logic              r_cphase;
  logic              w_cphase_nxt;

  logic [15:0]       r_fd;
  logic [15:0]       w_fd_nxt;
  logic              r_slwr_n;
  logic              w_slwr_n_nxt;
  logic              r_pktend_n;
  logic              w_pktend_n_nxt;
  logic [15:0]       r_pkt_cnt;
  logic [15:0]       w_pkt_cnt_nxt;
  logic              r_busy;
  logic              r_slrd_n;
  logic              r_sloe_n;
  logic [1:0]        r_fifoadr;

  logic              w_s_ready;
  logic              w_accept;

  // The source may only hand over a word while a packet is open and has room.
  assign w_s_ready  = (r_state == ST_BURST) && (r_wcnt < LP_PKT_WORDS) && i_enable;
  assign w_accept   = w_s_ready && i_s_valid;
  assign w_wcnt_inc = r_wcnt + LP_WCNT_ONE;
  assign w_idle_inc = sat_inc16(r_idle);
  assign w_qual_inc = r_qual + 2'd1;

  // Next-state and next-output decode; strobes idle high unless a cycle asks otherwise.
  always_comb begin
    w_state_nxt    = r_state;
    w_wcnt_nxt     = r_wcnt;
    w_idle_nxt     = r_idle;
    w_qual_nxt     = r_qual;
    w_gap_nxt      = r_gap;
    w_cphase_nxt   = r_cphase;
    w_fd_nxt       = r_fd;
    w_slwr_n_nxt   = 1'b1;
    w_pktend_n_nxt = 1'b1;
    w_pkt_cnt_nxt  = r_pkt_cnt;

    case (r_state)
      ST_IDLE: begin
        w_wcnt_nxt   = LP_WCNT_ZERO;
        w_idle_nxt   = 16'd0;
        w_qual_nxt   = 2'd0;
        w_gap_nxt    = 2'd0;
        w_cphase_nxt = 1'b0;
        if (i_enable) begin
          w_state_nxt = ST_ARM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ARM: begin
        // A fresh packet starts only after the FX2 reports room twice in a row.
        w_wcnt_nxt = LP_WCNT_ZERO;
        w_idle_nxt = 16'd0;
        if (!i_enable) begin
          w_qual_nxt  = 2'd0;
          w_state_nxt = ST_IDLE;
        end else if (i_flag_full_n) begin
          if (w_qual_inc == LP_ARM_QUAL) begin
            w_qual_nxt  = 2'd0;
            w_state_nxt = ST_BURST;
          end else begin
            w_qual_nxt  = w_qual_inc;
          end
        end else begin
          w_qual_nxt = 2'd0;
        end
      end

      ST_BURST: begin
        if (w_accept) begin
          // An accepted word is always written; a full packet is auto-committed by the FX2.
          w_fd_nxt     = i_s_data;
          w_slwr_n_nxt = 1'b0;
          w_idle_nxt   = 16'd0;
          if (w_wcnt_inc == LP_PKT_WORDS) begin
            w_wcnt_nxt    = LP_WCNT_ZERO;
            w_pkt_cnt_nxt = r_pkt_cnt + 16'd1;
            w_gap_nxt     = 2'd0;
            w_state_nxt   = ST_GAP;
          end else begin
            w_wcnt_nxt = w_wcnt_inc;
          end
        end else if (!i_enable) begin
          if (r_wcnt != LP_WCNT_ZERO) begin
            w_cphase_nxt = 1'b0;
            w_state_nxt  = ST_COMMIT;
          end else begin
            w_state_nxt  = ST_IDLE;
          end
        end else if (r_wcnt != LP_WCNT_ZERO) begin
          // Partial packet stalled: flush it once the source has been quiet long enough.
          w_idle_nxt = w_idle_inc;
          if (w_idle_inc >= LP_TIMEOUT) begin
            w_cphase_nxt = 1'b0;
            w_state_nxt  = ST_COMMIT;
          end else begin
            w_state_nxt  = ST_BURST;
          end
        end else begin
          w_idle_nxt = 16'd0;
        end
      end

      ST_COMMIT: begin
        // First cycle keeps SLWR high so PKTEND never overlaps a write.
        if (!r_cphase) begin
          w_cphase_nxt = 1'b1;
        end else begin
          w_cphase_nxt   = 1'b0;
          w_pktend_n_nxt = 1'b0;
          w_pkt_cnt_nxt  = r_pkt_cnt + 16'd1;
          w_wcnt_nxt     = LP_WCNT_ZERO;
          w_idle_nxt     = 16'd0;
          w_gap_nxt      = 2'd0;
          w_state_nxt    = ST_GAP;
        end
      end

      ST_GAP: begin
        w_qual_nxt = 2'd0;
        if (r_gap == LP_GAP_LAST) begin
          w_gap_nxt = 2'd0;
          if (i_enable) begin
            w_state_nxt = ST_ARM;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_gap_nxt = r_gap + 2'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and all pin outputs; reset abandons any open packet.
  always_ff @(posedge i_usb_ifclk) begin
    if (i_usb_reset) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= LP_WCNT_ZERO;
      r_idle     <= 16'd0;
      r_qual     <= 2'd0;
      r_gap      <= 2'd0;
      r_cphase   <= 1'b0;
      r_fd       <= 16'd0;
      r_slwr_n   <= 1'b1;
      r_pktend_n <= 1'b1;
      r_pkt_cnt  <= 16'd0;
      r_busy     <= 1'b0;
      r_slrd_n   <= 1'b1;
      r_sloe_n   <= 1'b1;
      r_fifoadr  <= FIFO_ADDR;
    end else begin
      r_state    <= w_state_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_idle     <= w_idle_nxt;
      r_qual     <= w_qual_nxt;
      r_gap      <= w_gap_nxt;
      r_cphase   <= w_cphase_nxt;
      r_fd       <= w_fd_nxt;
      r_slwr_n   <= w_slwr_n_nxt;
      r_pktend_n <= w_pktend_n_nxt;
      r_pkt_cnt  <= w_pkt_cnt_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_slrd_n   <= 1'b1;
      r_sloe_n   <= 1'b1;
      r_fifoadr  <= FIFO_ADDR;
    end
  end

  assign o_s_ready      = w_s_ready;
  assign o_usb_fd       = r_fd;
  assign o_usb_slwr_n   = r_slwr_n;
  assign o_usb_slrd_n   = r_slrd_n;
  assign o_usb_sloe_n   = r_sloe_n;
  assign o_usb_pktend_n = r_pktend_n;
  assign o_usb_fifoadr  = r_fifoadr;
  assign o_busy         = r_busy;
  assign o_pkt_cnt      = r_pkt_cnt;

endmodule

// File: tb/tb_usb_slfifo_wr_ctrl.sv
// Self-checking bench for usb_slfifo_wr_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model of the sequencer.
module tb_usb_slfifo_wr_ctrl;

  localparam int PKT  = 4;
  localparam int TO   = 4;
  localparam int GAP  = 2;
  localparam int QUAL = 2;

  localparam int M_OFF = 0, M_QUALIFY = 1, M_STREAM = 2, M_FLUSH = 3, M_SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst, en, val, flag;
  logic [15:0] dat;
  logic        o_ready, o_slwr_n, o_slrd_n, o_sloe_n, o_pktend_n, o_busy;
  logic [15:0] o_fd, o_pkt;
  logic [1:0]  o_fifoadr;

  usb_slfifo_wr_ctrl #(.PKT_WORDS(PKT), .IDLE_TIMEOUT(TO), .FIFO_ADDR(2'b10)) dut (
    .i_usb_ifclk(clk), .i_usb_reset(rst), .i_enable(en), .i_s_data(dat),
    .i_s_valid(val), .o_s_ready(o_ready), .i_flag_full_n(flag), .o_usb_fd(o_fd),
    .o_usb_slwr_n(o_slwr_n), .o_usb_slrd_n(o_slrd_n), .o_usb_sloe_n(o_sloe_n),
    .o_usb_pktend_n(o_pktend_n), .o_usb_fifoadr(o_fifoadr), .o_busy(o_busy),
    .o_pkt_cnt(o_pkt)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode plus countdowns, expected pin values.
  int          m_mode = M_OFF, m_words = 0, m_quiet = 0, m_run = 0, m_left = 0;
  logic [15:0] e_fd = 16'd0, e_pkt = 16'd0;
  logic        e_slwr_n = 1'b1, e_pktend_n = 1'b1;
  int          checks = 0, failures = 0;
  int          mon_wr = 0, mon_pe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, advance model at the edge, check outputs.
  task automatic step(input logic i_en, input logic i_v, input logic [15:0] i_d,
                      input logic i_f, input logic i_r, output logic acc);
    logic rdy;
    en = i_en; val = i_v; dat = i_d; flag = i_f; rst = i_r;
    #1;
    rdy = (m_mode == M_STREAM) && (m_words < PKT) && i_en;
    chk("s_ready", o_ready, rdy);
    acc = rdy && i_v && !i_r;
    @(posedge clk);
    e_slwr_n   = 1'b1;
    e_pktend_n = 1'b1;
    if (i_r) begin
      m_mode = M_OFF; m_words = 0; m_quiet = 0; m_run = 0; m_left = 0;
      e_fd = 16'd0; e_pkt = 16'd0;
    end else begin
      case (m_mode)
        M_OFF: begin
          if (i_en) begin m_mode = M_QUALIFY; m_run = 0; end
        end
        M_QUALIFY: begin
          if (!i_en) m_mode = M_OFF;
          else if (i_f) begin
            m_run++;
            if (m_run >= QUAL) begin m_mode = M_STREAM; m_words = 0; m_quiet = 0; end
          end else m_run = 0;
        end
        M_STREAM: begin
          if (rdy && i_v) begin
            e_fd = i_d; e_slwr_n = 1'b0; m_words++; m_quiet = 0;
            if (m_words == PKT) begin e_pkt = e_pkt + 16'd1; m_mode = M_SETTLE; m_left = GAP; end
          end else if (!i_en) begin
            if (m_words > 0) begin m_mode = M_FLUSH; m_left = 2; end
            else m_mode = M_OFF;
          end else if (m_words > 0) begin
            m_quiet++;
            if (m_quiet >= TO) begin m_mode = M_FLUSH; m_left = 2; end
          end
        end
        M_FLUSH: begin
          m_left--;
          if (m_left == 0) begin
            e_pktend_n = 1'b0; e_pkt = e_pkt + 16'd1; m_mode = M_SETTLE; m_left = GAP;
          end
        end
        M_SETTLE: begin
          m_left--;
          if (m_left == 0) begin m_mode = i_en ? M_QUALIFY : M_OFF; m_run = 0; end
        end
        default: m_mode = M_OFF;
      endcase
    end
    @(negedge clk);
    chk("slwr_n", o_slwr_n, e_slwr_n);
    chk("pktend_n", o_pktend_n, e_pktend_n);
    chk("fd", o_fd, e_fd);
    chk("pkt_cnt", o_pkt, e_pkt);
    chk("busy", o_busy, (m_mode != M_OFF));
    chk("slrd_n", o_slrd_n, 1'b1);
    chk("sloe_n", o_sloe_n, 1'b1);
    chk("fifoadr", o_fifoadr, 2'b10);
    if (o_slwr_n === 1'b0) mon_wr++;
    if (o_pktend_n === 1'b0) mon_pe++;
  endtask

  task automatic do_reset();
    logic a;
    step(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, a);
    step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, a);
    mon_wr = 0; mon_pe = 0;
  endtask

  // Feed words start..last back-to-back (bounded), returns next unsent word.
  task automatic feed(input logic [15:0] first, input logic [15:0] last, output logic [15:0] nxt);
    logic a;
    nxt = first;
    for (int k = 0; k < 60 && nxt <= last; k++) begin
      step(1'b1, 1'b1, nxt, 1'b1, 1'b0, a);
      if (a) nxt = nxt + 16'd1;
    end
    chk("feed_done", nxt, last + 16'd1);
  endtask

  task automatic idle_steps(input int n, input logic i_en);
    logic a;
    for (int k = 0; k < n; k++) step(i_en, 1'b0, 16'd0, 1'b1, 1'b0, a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a;
    logic [15:0] nxt;
    int          first_k, vpct;

    rst = 1'b1; en = 1'b0; val = 1'b0; dat = 16'd0; flag = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_slwr_n", o_slwr_n, 1'b1);
    chk("rst_pktend_n", o_pktend_n, 1'b1);
    chk("rst_fd", o_fd, 16'h0000);
    chk("rst_pkt_cnt", o_pkt, 16'h0000);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_fifoadr", o_fifoadr, 2'b10);

    // 1: two full packets back-to-back, no PKTEND
    do_reset();
    feed(16'd1, 16'd8, nxt);
    idle_steps(6, 1'b1);
    chk("t1_writes", mon_wr, 8);
    chk("t1_pktend", mon_pe, 0);
    chk("t1_pkt_cnt", o_pkt, 16'd2);

    // 2: three words then silence -> short-packet commit
    do_reset();
    feed(16'd1, 16'd3, nxt);
    idle_steps(15, 1'b1);
    chk("t2_writes", mon_wr, 3);
    chk("t2_pktend", mon_pe, 1);
    chk("t2_pkt_cnt", o_pkt, 16'd1);

    // 3: FX2 full holds off the packet; first write 3 edges after release
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, a);
    chk("t3_no_write", mon_wr, 0);
    first_k = 0;
    for (int k = 1; k <= 20 && first_k == 0; k++) begin
      step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, a);
      if (o_slwr_n === 1'b0) first_k = k;
    end
    chk("t3_latency", first_k, 3);

    // 4a: disable after two words -> PKTEND then idle
    do_reset();
    feed(16'd1, 16'd2, nxt);
    idle_steps(12, 1'b0);
    chk("t4_pktend", mon_pe, 1);
    chk("t4_busy", o_busy, 1'b0);
    chk("t4_pkt_cnt", o_pkt, 16'd1);
    // 4b: disable with an empty packet -> idle, no PKTEND
    mon_pe = 0;
    idle_steps(4, 1'b1);
    idle_steps(6, 1'b0);
    chk("t4b_pktend", mon_pe, 0);
    chk("t4b_busy", o_busy, 1'b0);

    // 5: reset during the third word of a burst
    do_reset();
    feed(16'd1, 16'd2, nxt);
    step(1'b1, 1'b1, 16'd3, 1'b1, 1'b1, a);
    chk("t5_slwr_n", o_slwr_n, 1'b1);
    chk("t5_pktend_n", o_pktend_n, 1'b1);
    chk("t5_pkt_cnt", o_pkt, 16'd0);
    chk("t5_busy", o_busy, 1'b0);
    mon_pe = 0;
    idle_steps(10, 1'b0);
    chk("t5_no_pktend", mon_pe, 0);

    // 6: packet counter wraps from FFFF to 0
    do_reset();
    force dut.r_pkt_cnt = 16'hFFFF;
    e_pkt = 16'hFFFF;
    step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, a);
    release dut.r_pkt_cnt;
    feed(16'd1, 16'd4, nxt);
    idle_steps(6, 1'b1);
    chk("t6_wrap", o_pkt, 16'h0000);

    // Random traffic with lulls, full flag blips, disables and rare resets
    do_reset();
    vpct = 90;
    for (int k = 0; k < 3000; k++) begin
      if ((k % 64) == 0) begin
        case ($urandom_range(0, 3))
          0: vpct = 0;
          1: vpct = 30;
          2: vpct = 90;
          default: vpct = 100;
        endcase
      end
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < vpct),
           16'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 999) == 0), a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
